bank_rd_streamer: RTL and testbench

//  Read-side address generator and output buffer for one 64k data bank.

---
 rtl/bank_rd_streamer.sv | 198 +++++++++++++++++++
 tb/tb_bank_rd_streamer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_rd_streamer.sv
// bank_rd_streamer: read-side address generator and 2-entry output buffer
// for one data bank with a 1-cycle registered read port.
//
// Optional build macro: BANK_RD_STALL_CNT_EN adds the 16-bit stall_cnt
// output (cycles with out_valid && !out_ready, saturating, cleared by an
// accepted start).
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no job; start accepted here (count==0 only pulses done)
// S_RUN   | issuing bank reads while words remain and buffer room exists
// S_DRAIN | all reads issued; waiting for the out_last word to be accepted
`timescale 1ns/1ps

module bank_rd_streamer #(
  parameter int W = 64,
  parameter int A = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [A-1:0] base_addr,
  input  logic [A-1:0] stride,
  input  logic [A-1:0] count,
  output logic         busy,
  output logic         done,
  output logic         bank_rd_en,
  output logic [A-1:0] bank_rd_addr,
  input  logic [W-1:0] bank_rd_word,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_word,
  output logic         out_last
`ifdef BANK_RD_STALL_CNT_EN
  ,
  output logic [15:0]  stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [A-1:0]   addr_q, addr_d;
  logic [A-1:0]   stride_q, stride_d;
  logic [A-1:0]   remaining_q, remaining_d;
  logic           inflight_q, inflight_d;
  logic           inflight_last_q, inflight_last_d;
  logic [W-1:0]   buf_word_q [2];
  logic [W-1:0]   buf_word_d [2];
  logic [1:0]     buf_last_q, buf_last_d;
  logic           head_q, head_d;
  logic [1:0]     occ_q, occ_d;
  logic           done_q, done_d;

  logic           pop;
  logic           push;
  logic           issue;
  logic           start_acc;
  logic           tail;
  logic [2:0]     fill;

  // State register and all datapath flops; synchronous reset also drops any in-flight word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      stride_q        <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      buf_word_q[0]   <= '0;
      buf_word_q[1]   <= '0;
      buf_last_q      <= '0;
      head_q          <= 1'b0;
      occ_q           <= '0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      stride_q        <= stride_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      buf_word_q[0]   <= buf_word_d[0];
      buf_word_q[1]   <= buf_word_d[1];
      buf_last_q      <= buf_last_d;
      head_q          <= head_d;
      occ_q           <= occ_d;
      done_q          <= done_d;
    end
  end

  // Next-state logic: the last read moves to DRAIN, the accepted last word returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start && (count != '0)) state_d = S_RUN;
      end
      S_RUN: begin
        if (issue && (remaining_q == {{(A-1){1'b0}}, 1'b1})) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && out_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs and handshake terms; a read is issued only if its word is guaranteed a buffer slot.
  always_comb begin
    busy         = (state_q != S_IDLE);
    done         = done_q;
    out_valid    = (occ_q != 2'd0);
    out_word     = buf_word_q[head_q];
    out_last     = out_valid & buf_last_q[head_q];
    bank_rd_addr = addr_q;
    pop          = out_valid & out_ready;
    push         = inflight_q;
    start_acc    = start & (state_q == S_IDLE);
    fill         = {1'b0, occ_q} + {2'b00, inflight_q};
    issue        = (state_q == S_RUN) && (remaining_q != '0) &&
                   (fill < (3'd2 + {2'b00, pop}));
    bank_rd_en   = issue;
  end

  // Job counters, address stepping, in-flight tracking and the 2-entry circular buffer.
  always_comb begin
    addr_d          = addr_q;
    stride_d        = stride_q;
    remaining_d     = remaining_q;
    done_d          = 1'b0;
    buf_word_d[0]   = buf_word_q[0];
    buf_word_d[1]   = buf_word_q[1];
    buf_last_d      = buf_last_q;
    head_d          = head_q;
    occ_d           = occ_q;
    tail            = head_q ^ occ_q[0];

    if (start_acc) begin
      addr_d      = base_addr;
      stride_d    = stride;
      remaining_d = count;
      if (count == '0) done_d = 1'b1;
    end

    if (issue) begin
      addr_d      = addr_q + stride_q;
      remaining_d = remaining_q - {{(A-1){1'b0}}, 1'b1};
    end

    inflight_d      = issue;
    inflight_last_d = issue && (remaining_q == {{(A-1){1'b0}}, 1'b1});

    if ((state_q == S_DRAIN) && pop && out_last) done_d = 1'b1;

    // With occ==2 a push only happens alongside a pop, so tail==head reuses the freed slot.
    if (push) begin
      buf_word_d[tail] = bank_rd_word;
      buf_last_d[tail] = inflight_last_q;
    end

    if (pop) head_d = ~head_q;

    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

`ifdef BANK_RD_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Backpressure cycle counter, saturating, restarted by each accepted job.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_acc) begin
      stall_cnt_d = '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bank_rd_streamer.sv
// Directed bench for bank_rd_streamer with an address/data scoreboard and a
// registered bank model. Build with BANK_RD_STALL_CNT_EN to also check stall_cnt.
`timescale 1ns/1ps

module tb_bank_rd_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr, stride, count;
  logic        busy, done, bank_rd_en;
  logic [9:0]  bank_rd_addr;
  logic [63:0] bank_rd_word;
  logic        out_valid, out_ready, out_last;
  logic [63:0] out_word;
`ifdef BANK_RD_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  int cyc;
  int nrd, npop, ndone, first_rd, last_rd, first_pop, last_pop, done_cyc, snap_rd;
  logic        prev_stall;
  logic [63:0] prev_word;

  logic [9:0]  exp_addr [$];
  logic [63:0] exp_word [$];

  bank_rd_streamer #(.W(64), .A(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .stride       (stride),
    .count        (count),
    .busy         (busy),
    .done         (done),
    .bank_rd_en   (bank_rd_en),
    .bank_rd_addr (bank_rd_addr),
    .bank_rd_word (bank_rd_word),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_word     (out_word),
    .out_last     (out_last)
`ifdef BANK_RD_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] bank_data(input logic [9:0] a);
    return {22'h2B5A5, a, 22'h0F0F1, ~a};
  endfunction

  // Registered bank: word appears the cycle after the read; junk otherwise.
  always @(posedge clk) begin
    if (bank_rd_en) bank_rd_word <= bank_data(bank_rd_addr);
    else            bank_rd_word <= {$urandom, $urandom};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples one cycle's outputs #1 after the falling edge.
  task automatic sample();
    logic [9:0]  a;
    logic [63:0] w;
    #1;
    if (bank_rd_en) begin
      nrd++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
      if (exp_addr.size() == 0) chk("rd_extra", 1, 0);
      else begin
        a = exp_addr.pop_front();
        chk("rd_addr", bank_rd_addr, a);
      end
    end
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_word", out_word, prev_word);
    end
    if (out_valid && out_ready) begin
      npop++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      if (exp_word.size() == 0) chk("out_extra", 1, 0);
      else begin
        w = exp_word.pop_front();
        chk("out_word", out_word, w);
        chk("out_last", out_last, exp_word.size() == 0);
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_word  = out_word;
    if (done && cyc != 0) begin
      ndone++;
      done_cyc = cyc;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc = 100 + k;
      start = 1'b0;
      out_ready = 1'b1;
      sample();
      chk("idle_done", done, 1'b0);
      chk("idle_valid", out_valid, 1'b0);
      chk("idle_rd_en", bank_rd_en, 1'b0);
    end
  endtask

  // Runs one job from the current cycle (cycle 0); returns in the done cycle.
  task automatic run_job(input logic [9:0] b, input logic [9:0] s, input logic [9:0] n,
                         input int st0, input int st1, input int ign_cyc, input int snap_cyc);
    logic [9:0] a;
    cyc = 0; nrd = 0; npop = 0; ndone = 0; done_cyc = -1; snap_rd = -1;
    first_rd = -1; last_rd = -1; first_pop = -1; last_pop = -1;
    a = b;
    for (int i = 0; i < int'(n); i++) begin
      exp_addr.push_back(a);
      exp_word.push_back(bank_data(a));
      a = a + s;
    end
    start = 1'b1; base_addr = b; stride = s; count = n;
    out_ready = !(0 >= st0 && 0 <= st1);
    sample();
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      cyc = k;
      start = (k == ign_cyc);
      if (start) begin
        base_addr = 10'h2AA; stride = 10'd1; count = 10'd3;
      end
      out_ready = !(k >= st0 && k <= st1);
      sample();
      if (k == snap_cyc) snap_rd = nrd;
      if (ndone != 0) break;
    end
    start = 1'b0;
    chk("job_timeout", ndone != 0, 1'b1);
    chk("sb_empty", exp_addr.size() + exp_word.size(), 0);
    chk("busy_at_done", busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; stride = '0; count = '0; out_ready = 1'b1;
    prev_stall = 1'b0; prev_word = '0; cyc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rd_en", bank_rd_en, 1'b0);
    chk("rst_rd_addr", bank_rd_addr, 10'h000);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_word", out_word, 64'h0);
    rst = 1'b0;
    idle(1);

    // Straight 4-word stream, then a job chained in the done cycle that wraps the address.
    @(negedge clk);
    run_job(10'h010, 10'd1, 10'd4, 1000, 0, -1, -1);
    chk("t1_first_rd", first_rd, 1);
    chk("t1_last_rd", last_rd, 4);
    chk("t1_first_pop", first_pop, 3);
    chk("t1_last_pop", last_pop, 6);
    chk("t1_done_cyc", done_cyc, 7);
    run_job(10'h3FE, 10'd3, 10'd3, 1000, 0, -1, -1);
    chk("t2_first_rd", first_rd, 1);
    chk("t2_nrd", nrd, 3);
    chk("t2_done_cyc", done_cyc, 6);
    idle(2);

    // Backpressure for cycles 3-10: only two reads may be outstanding.
    @(negedge clk);
    run_job(10'h100, 10'd5, 10'd8, 3, 10, -1, 10);
    chk("t3_rd_at_c10", snap_rd, 2);
    chk("t3_npop", npop, 8);
`ifdef BANK_RD_STALL_CNT_EN
    chk("t3_stall_cnt", stall_cnt, 16'd8);
`endif
    idle(1);

    // Empty job.
    @(negedge clk);
    run_job(10'h077, 10'd1, 10'd0, 1000, 0, -1, -1);
    chk("t4_done_cyc", done_cyc, 1);
    chk("t4_nrd", nrd, 0);
    chk("t4_npop", npop, 0);
    idle(2);

    // Start while busy is ignored; 5 stall cycles.
    @(negedge clk);
    run_job(10'h020, 10'd2, 10'd6, 3, 7, 2, -1);
    chk("t6_npop", npop, 6);
    chk("t6_ndone", ndone, 1);
`ifdef BANK_RD_STALL_CNT_EN
    chk("t6_stall_cnt", stall_cnt, 16'd5);
`endif
    idle(1);

    // Reset in cycle 4 of a 16-word job.
    @(negedge clk);
    cyc = 0; nrd = 0; npop = 0; ndone = 0;
    first_rd = -1; last_rd = -1; first_pop = -1; last_pop = -1;
    begin
      logic [9:0] a;
      a = 10'h200;
      for (int i = 0; i < 16; i++) begin
        exp_addr.push_back(a);
        exp_word.push_back(bank_data(a));
        a = a + 10'd1;
      end
    end
    start = 1'b1; base_addr = 10'h200; stride = 10'd1; count = 10'd16; out_ready = 1'b1;
    sample();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      cyc = k;
      start = 1'b0;
      rst = (k == 4);
      sample();
    end
    chk("t5_busy", busy, 1'b0);
    chk("t5_done", done, 1'b0);
    chk("t5_rd_en", bank_rd_en, 1'b0);
    chk("t5_rd_addr", bank_rd_addr, 10'h000);
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_last", out_last, 1'b0);
    chk("t5_word", out_word, 64'h0);
`ifdef BANK_RD_STALL_CNT_EN
    chk("t5_stall_cnt", stall_cnt, 16'd0);
`endif
    exp_addr.delete();
    exp_word.delete();
    idle(3);
    @(negedge clk);
    run_job(10'h055, 10'd7, 10'd5, 1000, 0, -1, -1);
    chk("t5b_npop", npop, 5);
    chk("t5b_done_cyc", done_cyc, 8);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
